// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch front end. Issues word fetches
// over a request/grant interface and buffers in-order responses with their PCs.
// It presents them to decode over valid/ready. A redirect flushes the queue
// and marks every in-flight response as stale, so that response is dropped.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int          AW       = $clog2(DEPTH);
    localparam int          CW       = AW + 1;
    localparam logic [31:0] START_PC = RESET_PC & ~32'h3;
    localparam logic [CW+1:0] LIMIT  = (CW+2)'(DEPTH);

    // Queue storage (data only, never reset)
    logic [31:0]   q_word [DEPTH];
    logic [31:0]   q_pc   [DEPTH];

    // Control state
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count, outstanding, discard;
    logic [31:0]   fetch_pc, resp_pc;

    logic [CW+1:0] occupancy;
    logic          credit, grant, rsp_drop, rsp_keep, pop;
    logic [31:0]   target_pc;

    // Every granted request reserves a slot until its response is either
    // queued (then freed by a pop) or dropped as stale. The queue therefore
    // cannot overflow, and mem_req cannot fall without a grant.
    assign occupancy = (CW+2)'(count) + (CW+2)'(outstanding) + (CW+2)'(discard);
    assign credit    = occupancy < LIMIT;
    assign target_pc = redirect_pc & ~32'h3;

    assign mem_req  = RST_N & credit & ~redirect;
    assign mem_addr = fetch_pc;
    assign grant    = mem_req & mem_gnt;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_drop = mem_rvalid & (discard != '0);
    assign rsp_keep = mem_rvalid & (discard == '0) & (outstanding != '0);

    assign inst_valid = RST_N & (count != '0);
    assign inst       = inst_valid ? q_word[head] : 32'h0;
    assign inst_pc    = !RST_N ? START_PC : (inst_valid ? q_pc[head] : resp_pc);
    assign pop        = inst_valid & inst_ready;

    // Fetch/response PCs, queue pointers and credit counters
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            fetch_pc    <= START_PC;
            resp_pc     <= START_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect) begin
            // Anything still in flight after this edge becomes stale. A response
            // that arrives in this cycle is consumed here and dropped.
            fetch_pc    <= target_pc;
            resp_pc     <= target_pc;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= discard + outstanding - CW'(rsp_drop) - CW'(rsp_keep);
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (rsp_keep) begin
                resp_pc <= resp_pc + 32'd4;
                tail    <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            outstanding <= outstanding + CW'(grant) - CW'(rsp_keep);
            discard     <= discard - CW'(rsp_drop);
            count       <= count + CW'(rsp_keep) - CW'(pop);
        end
    end

    // Capture accepted response words together with the PC they belong to
    always_ff @(posedge CLK) begin
        if (rsp_keep && !redirect) begin
            q_word[tail] <= mem_rdata;
            q_pc[tail]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scenario tasks plus a randomized run. The bench checks the
// DUT against a queue-based reference. In-flight requests are tracked with a
// stale flag, and delivered entries carry the address that was fetched.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK(CLK), .RST_N(RST_N), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] addr; bit stale; } req_t;
    typedef struct { logic [31:0] word; logic [31:0] pc; } ent_t;

    req_t        inflight [$];
    ent_t        fifo [$];
    logic [31:0] m_fetch_pc = RESET_PC;
    bit          gnt_en = 0, rsp_en = 0;
    bit          exp_req, exp_valid;
    logic [31:0] exp_addr, exp_inst, exp_pc;
    int          nerr = 0, nchecks = 0;

    function automatic logic [31:0] wordof(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    // Drive memory for this cycle and compute the expected outputs
    task automatic prep();
        mem_gnt    = gnt_en;
        mem_rvalid = rsp_en && (inflight.size() > 0);
        mem_rdata  = mem_rvalid ? wordof(inflight[0].addr) : 32'h0;
        #1;
        exp_req   = RST_N && !redirect && ((fifo.size() + inflight.size()) < DEPTH);
        exp_addr  = m_fetch_pc;
        exp_valid = RST_N && (fifo.size() > 0);
        exp_inst  = 32'h0;
        exp_pc    = 32'h0;
        if (exp_valid) begin
            exp_inst = fifo[0].word;
            exp_pc   = fifo[0].pc;
        end
    endtask

    // Clock edge, then advance the reference with what happened in the cycle
    task automatic tick();
        bit          r   = RST_N;
        bit          rd  = redirect;
        bit          g   = exp_req && mem_gnt;
        bit          rv  = mem_rvalid;
        bit          p   = exp_valid && inst_ready;
        logic [31:0] tgt = redirect_pc & ~32'h3;
        req_t        f;
        @(posedge CLK);
        if (!r) begin
            fifo.delete();
            inflight.delete();
            m_fetch_pc = RESET_PC;
        end else if (rd) begin
            if (rv) f = inflight.pop_front();
            foreach (inflight[i]) inflight[i].stale = 1;
            fifo.delete();
            m_fetch_pc = tgt;
        end else begin
            if (p) void'(fifo.pop_front());
            if (rv) begin
                f = inflight.pop_front();
                if (!f.stale) fifo.push_back('{word: wordof(f.addr), pc: f.addr});
            end
            if (g) begin
                inflight.push_back('{addr: m_fetch_pc, stale: 1'b0});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic drain();
        gnt_en = 0; rsp_en = 1; inst_ready = 1; redirect = 0;
        for (int i = 0; i < 40 && (inflight.size() > 0 || fifo.size() > 0); i++) begin
            prep(); tick();
        end
        prep();
        nchecks++;
        if (inst_valid !== 1'b0 || inflight.size() != 0) begin
            nerr++; $display("FAIL drain: inst_valid=%b inflight=%0d, want 0/0", inst_valid, inflight.size());
        end
    endtask

    task automatic do_reset();
        drain();
        RST_N = 0; gnt_en = 0; rsp_en = 0; inst_ready = 0; redirect = 0;
        prep(); tick(); prep(); tick();
        RST_N = 1;
    endtask

    task automatic test_reset();
        RST_N = 0; gnt_en = 0; rsp_en = 0;
        prep(); tick(); prep();
        nchecks++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL reset_req: got %b want 0", mem_req); end
        nchecks++; if (inst_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        nchecks++; if (inst !== 32'h0) begin nerr++; $display("FAIL reset_inst: got %h want 0", inst); end
        nchecks++; if (inst_pc !== RESET_PC) begin nerr++; $display("FAIL reset_pc: got %h want %h", inst_pc, RESET_PC); end
        tick();
        RST_N = 1;
    endtask

    task automatic test_stream();
        gnt_en = 1; rsp_en = 1; inst_ready = 1;
        for (int i = 0; i < 10; i++) begin
            prep();
            nchecks++; if (mem_req !== 1'b1 || mem_addr !== 32'(4*i)) begin
                nerr++; $display("FAIL stream_addr[%0d]: got req=%b addr=%h want 1/%h", i, mem_req, mem_addr, 32'(4*i)); end
            nchecks++; if (inst_valid !== (i >= 2)) begin
                nerr++; $display("FAIL stream_valid[%0d]: got %b want %b", i, inst_valid, (i >= 2)); end
            if (i >= 2) begin
                nchecks++; if (inst_pc !== 32'(4*(i-2)) || inst !== wordof(32'(4*(i-2)))) begin
                    nerr++; $display("FAIL stream_data[%0d]: got pc=%h inst=%h want %h/%h", i, inst_pc, inst, 32'(4*(i-2)), wordof(32'(4*(i-2)))); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int ngr = 0;
        do_reset();
        gnt_en = 1; rsp_en = 1; inst_ready = 0;
        for (int i = 0; i < 8; i++) begin
            prep();
            if (mem_req && mem_gnt) begin
                nchecks++; if (mem_addr !== 32'(4*ngr)) begin
                    nerr++; $display("FAIL bp_addr: got %h want %h", mem_addr, 32'(4*ngr)); end
                ngr++;
            end
            tick();
        end
        inst_ready = 1;
        prep();
        nchecks++; if (ngr != 4) begin nerr++; $display("FAIL bp_grants: got %0d want 4", ngr); end
        nchecks++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL bp_req_full: got %b want 0", mem_req); end
        nchecks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            nerr++; $display("FAIL bp_head: got v=%b pc=%h want 1/0", inst_valid, inst_pc); end
        tick();
        inst_ready = 0;
        prep();
        nchecks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
            nerr++; $display("FAIL bp_resume: got req=%b addr=%h want 1/10", mem_req, mem_addr); end
        nchecks++; if (inst_pc !== 32'h4) begin nerr++; $display("FAIL bp_pop: got pc=%h want 4", inst_pc); end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        inst_ready = 0; gnt_en = 1;
        rsp_en = 0; prep(); tick();
        rsp_en = 1; prep(); tick();
        rsp_en = 1; prep(); tick();
        rsp_en = 0; prep(); tick();
        gnt_en = 0; rsp_en = 0; redirect = 1; redirect_pc = 32'h103;
        prep();
        nchecks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            nerr++; $display("FAIL ri_before: got v=%b pc=%h want 1/0", inst_valid, inst_pc); end
        nchecks++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL ri_req_redirect: got %b want 0", mem_req); end
        tick();
        redirect = 0; rsp_en = 1; gnt_en = 0;
        prep();
        nchecks++; if (inst_valid !== 1'b0) begin nerr++; $display("FAIL ri_flush: got %b want 0", inst_valid); end
        nchecks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
            nerr++; $display("FAIL ri_newpc: got req=%b addr=%h want 1/100", mem_req, mem_addr); end
        tick();
        gnt_en = 1; prep();
        nchecks++; if (inst_valid !== 1'b0) begin nerr++; $display("FAIL ri_drop1: got %b want 0", inst_valid); end
        tick();
        gnt_en = 0; prep();
        nchecks++; if (inst_valid !== 1'b0) begin nerr++; $display("FAIL ri_drop2: got %b want 0", inst_valid); end
        tick();
        prep();
        nchecks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== wordof(32'h100)) begin
            nerr++; $display("FAIL ri_first: got v=%b pc=%h inst=%h want 1/100/%h", inst_valid, inst_pc, inst, wordof(32'h100)); end
    endtask

    task automatic test_redirect_coincident();
        do_reset();
        inst_ready = 0;
        gnt_en = 1; rsp_en = 0; prep(); tick();
        gnt_en = 0; rsp_en = 1; prep(); tick();
        gnt_en = 1; rsp_en = 0; prep(); tick();
        gnt_en = 1; rsp_en = 1; inst_ready = 1; redirect = 1; redirect_pc = 32'h40;
        prep();
        nchecks++; if (mem_req !== 1'b0 || mem_rvalid !== 1'b1 || inst_valid !== 1'b1) begin
            nerr++; $display("FAIL rc_setup: got req=%b rvalid=%b v=%b want 0/1/1", mem_req, mem_rvalid, inst_valid); end
        tick();
        redirect = 0; rsp_en = 0;
        prep();
        nchecks++; if (inst_valid !== 1'b0) begin nerr++; $display("FAIL rc_flush: got %b want 0", inst_valid); end
        nchecks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
            nerr++; $display("FAIL rc_newpc: got req=%b addr=%h want 1/40", mem_req, mem_addr); end
        tick();
        gnt_en = 0; rsp_en = 1; prep();
        nchecks++; if (inst_valid !== 1'b0) begin nerr++; $display("FAIL rc_wait: got %b want 0", inst_valid); end
        tick();
        prep();
        nchecks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin
            nerr++; $display("FAIL rc_first: got v=%b pc=%h want 1/40", inst_valid, inst_pc); end
    endtask

    task automatic test_grant_stall();
        do_reset();
        inst_ready = 1; rsp_en = 1; gnt_en = 1;
        prep(); tick();
        gnt_en = 0;
        for (int i = 0; i < 3; i++) begin
            prep();
            nchecks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin
                nerr++; $display("FAIL stall_hold[%0d]: got req=%b addr=%h want 1/4", i, mem_req, mem_addr); end
            tick();
        end
        gnt_en = 1; prep();
        nchecks++; if (mem_addr !== 32'h4) begin nerr++; $display("FAIL stall_gnt: got %h want 4", mem_addr); end
        tick();
        gnt_en = 0; prep();
        nchecks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
            nerr++; $display("FAIL stall_next: got req=%b addr=%h want 1/8", mem_req, mem_addr); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        inst_ready = 0; gnt_en = 1; rsp_en = 1;
        for (int i = 0; i < 8; i++) begin prep(); tick(); end
        prep();
        nchecks++; if (inst_valid !== 1'b1 || mem_req !== 1'b0) begin
            nerr++; $display("FAIL mid_full: got v=%b req=%b want 1/0", inst_valid, mem_req); end
        RST_N = 0; gnt_en = 0; rsp_en = 0;
        prep(); tick(); prep();
        nchecks++; if (inst_valid !== 1'b0 || mem_req !== 1'b0) begin
            nerr++; $display("FAIL mid_reset: got v=%b req=%b want 0/0", inst_valid, mem_req); end
        nchecks++; if (inst !== 32'h0 || inst_pc !== RESET_PC) begin
            nerr++; $display("FAIL mid_reset_out: got inst=%h pc=%h want 0/%h", inst, inst_pc, RESET_PC); end
        tick();
        RST_N = 1; prep();
        nchecks++; if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
            nerr++; $display("FAIL mid_restart: got req=%b addr=%h want 1/%h", mem_req, mem_addr, RESET_PC); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            gnt_en      = ($urandom % 4) != 0;
            rsp_en      = ($urandom % 3) != 0;
            inst_ready  = ($urandom % 4) != 0;
            redirect    = ($urandom % 16) == 0;
            redirect_pc = $urandom;
            prep();
            nchecks++; if (mem_req !== exp_req) begin
                nerr++; $display("FAIL rnd_req[%0d]: got %b want %b", i, mem_req, exp_req); end
            if (exp_req) begin
                nchecks++; if (mem_addr !== exp_addr) begin
                    nerr++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, mem_addr, exp_addr); end
            end
            nchecks++; if (inst_valid !== exp_valid) begin
                nerr++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, inst_valid, exp_valid); end
            if (exp_valid) begin
                nchecks++; if (inst !== exp_inst || inst_pc !== exp_pc) begin
                    nerr++; $display("FAIL rnd_data[%0d]: got %h/%h want %h/%h", i, inst, inst_pc, exp_inst, exp_pc); end
            end
            tick();
        end
        redirect = 0;
        drain();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_coincident();
        test_grant_stall();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front end that sits directly upstream of the instruction parser/decode stage.
- Generates sequential word fetch addresses and issues them to instruction memory over a request/grant + response-valid handshake.
- Buffers returned instruction words with their PCs in a small in-order queue, and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
- DEPTH, 4, queue entries and maximum in-flight memory requests (power of 2, >=2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  synchronous active-low reset.
- redirect  in  1  load a new fetch PC (taken branch/jump), one-cycle pulse.
- redirect_pc  in  32  target PC; bits [1:0] ignored (forced 0).
- mem_req  out  1  fetch request valid.
- mem_addr  out  32  fetch word address, low 2 bits always 0.
- mem_gnt  in  1  memory accepts request this cycle (counts only when mem_req=1).
- mem_rvalid  in  1  response word valid; responses return in request order.
- mem_rdata  in  32  instruction word.
- inst_valid  out  1  head entry valid.
- inst_ready  in  1  decode accepts head entry.
- inst  out  32  head instruction word.
- inst_pc  out  32  PC of head instruction.

Behaviour:
- Reset (RST_N=0 at edge):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC; queue empty; outstanding=0; discard=0.
  - Outputs while reset is held: mem_req=0, inst_valid=0, inst=0, inst_pc=RESET_PC.
  - Reset mid-operation abandons all in-flight requests. Any response arriving after reset is NOT discarded, so the bench must ensure memory is idle during reset.
- Credit:
  - credit = (count + outstanding + discard) < DEPTH.
  - mem_req = credit & !redirect; mem_addr = fetch_pc.
  - Once asserted, mem_req and mem_addr hold stable until mem_gnt. The only exception is a redirect, which may withdraw the request.
- Grant (mem_req & mem_gnt): fetch_pc += 4 (wraps mod 2^32), outstanding += 1.
- Response (mem_rvalid):
  - If discard>0: discard -= 1 and the data is dropped.
  - Otherwise: outstanding -= 1; push {mem_rdata, resp_pc} into the queue; resp_pc += 4.
  - A response while outstanding=discard=0 is a protocol error. The block ignores it; the bench asserts it never occurs.
- Pop (inst_valid & inst_ready): head advances.
  - The write-side latency is one cycle: a response at edge N is visible on inst/inst_valid after edge N.
  - Push and pop in the same cycle leave count unchanged.
  - A full queue cannot overflow, because credit guarantees it.
- Redirect (has priority over everything except reset):
  - fetch_pc = resp_pc = {redirect_pc[31:2],2'b00}.
  - Queue flushed (count=0); any pop that cycle is ignored.
  - discard_next = discard + outstanding − (rvalid & discard>0 ? 1 : 0) − (rvalid & discard==0 ? 1 : 0).
  - In short: every request granted before this cycle whose response has not arrived by this cycle's edge is discarded.
  - A response arriving in the redirect cycle is dropped.
  - outstanding_next = 0.
  - No grant can occur in the redirect cycle, because mem_req=0.
- Redirect from empty/idle: mem_req reasserts the cycle after the redirect at the new PC.
- Steady state with single-cycle memory (gnt=1, rvalid one cycle after grant) and inst_ready=1: one instruction per cycle.
- Counters count, outstanding and discard each have width clog2(DEPTH)+1.

Test Plan:
- Reset then stream: RST_N low 2 cycles, memory grants immediately and responds next cycle, inst_ready=1 → mem_addr 0,4,8,… on consecutive cycles; inst_pc 0,4,8 with matching words; first inst_valid 2 cycles after reset release.
- Backpressure: inst_ready=0 → exactly 4 grants (0x0–0xC), then mem_req=0; queue holds 4. Raise inst_ready for 1 cycle → one pop, mem_req reasserts at 0x10 next cycle.
- Redirect with in-flight: 2 granted requests (0x8, 0xC) pending and queue holding 0x0/0x4; redirect to 0x103 → queue empty, next mem_addr=0x100, both late responses dropped, first inst_pc=0x100.
- Redirect coincident with rvalid and pop: 1 outstanding, rvalid, inst_ready and redirect to 0x40 all high in the same cycle → response dropped, discard=0, no instruction delivered until the 0x40 response arrives.
- Grant stall: mem_gnt low 3 cycles → mem_req high and mem_addr stable at the same value throughout; fetch_pc advances only on the grant cycle.
- Reset mid-stream: assert RST_N=0 with a full queue and idle memory → next cycle inst_valid=0, mem_req=0; after release, fetching restarts at RESET_PC.
